bcd_display_scan: RTL and testbench

Two-digit multiplexed 7-segment display controller for the lab board. It accepts a 4-bit binary value (0–15) over a valid/ready handshake and splits it into tens and units digits with the existing `decoderBDC`. It then time-multiplexes the two digits onto a shared active-low segment bus, with anti-ghosting blank gaps and optional leading-zero blanking. It sits between any value producer (counter, ALU result, switches) and the board's display pins.

---
 rtl/bcd_disp_pkg.sv | 8 +
 rtl/decoderBDC.sv | 9 +
 rtl/seg7_enc.sv | 9 +
 rtl/bcd_display_scan.sv | 81 ++++++++
 tb/tb_bcd_display_scan.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared scan states and active-low 7-segment patterns.
package bcd_disp_pkg;
    typedef enum logic [2:0] {OFF, UNITS, GAP_T, TENS, GAP_U} disp_state_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
endpackage

// File: rtl/decoderBDC.sv
// decoderBDC: splits a 4-bit binary value (0-15) into tens and units digits.
module decoderBDC (
    input  logic [3:0] x,
    output logic [3:0] y1,
    output logic [3:0] y0
);
    assign y1 = (x >= 4'd10) ? 4'd1 : 4'd0;
    assign y0 = (x >= 4'd10) ? x - 4'd10 : x;
endmodule

// File: rtl/seg7_enc.sv
// seg7_enc: 4-bit digit to active-low {g,f,e,d,c,b,a}; non-decimal codes are dark.
module seg7_enc
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    assign seg_o = (digit_i > 4'd9) ? SEG_OFF : SEG_DIGIT[digit_i];
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: two-digit multiplexed 7-segment controller with blank gaps
// and optional leading-zero blanking; outputs registered from next state.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int GAP_CYC       = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] shown
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST_SCAN = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYC - 1);

    disp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    value_q, value_d;
    logic [6:0]    seg_q, seg_d, enc_seg;
    logic [1:0]    an_q, an_d;
    logic [3:0]    tens, units, digit;
    logic          cap, done, dark_tens;

    assign in_ready = (state_q == OFF || state_q == GAP_T || state_q == GAP_U) && !blank;
    assign cap      = in_valid && in_ready;
    assign value_d  = cap ? value : value_q;
    assign done     = cnt_q == ((state_q == UNITS || state_q == TENS) ? LAST_SCAN : LAST_GAP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     state_d = cap  ? GAP_U : OFF;
            UNITS:   state_d = done ? GAP_T : UNITS;
            GAP_T:   state_d = done ? TENS  : GAP_T;
            TENS:    state_d = done ? GAP_U : TENS;
            GAP_U:   state_d = done ? UNITS : GAP_U;
            default: state_d = OFF;
        endcase
        if (blank) state_d = OFF;
    end

    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    // Digits come from the next value so a gap capture shows on the next lit slot.
    decoderBDC u_dec (.x(value_d), .y1(tens), .y0(units));
    assign digit = (state_d == TENS) ? tens : units;
    seg7_enc u_enc (.digit_i(digit), .seg_o(enc_seg));

    assign dark_tens = BLANK_LEADING && tens == 4'd0;
    assign an_d  = (state_d == UNITS) ? 2'b10 :
                   (state_d == TENS && !dark_tens) ? 2'b01 : 2'b11;
    assign seg_d = (an_d == 2'b11) ? SEG_OFF : enc_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            value_q <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign shown = value_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed scan timelines checked by a per-cycle scoreboard.
module tb_bcd_display_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] value = 4'd0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] shown;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       rdy;
        logic [3:0] shown;
    } exp_t;

    localparam logic [6:0] ENC [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    bcd_display_scan #(.SCAN_DIV(4), .GAP_CYC(1), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .value(value), .blank(blank), .seg(seg), .an(an), .shown(shown)
    );

    always #5 clk = ~clk;

    // Monitor: each cycle with an expectation queued, compare the displayed state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({seg, an, in_ready, shown} !== e) begin
                    errors++;
                    $display("FAIL slot t=%0t got seg=%h an=%b rdy=%b shown=%0d exp seg=%h an=%b rdy=%b shown=%0d",
                             $time, seg, an, in_ready, shown, e.seg, e.an, e.rdy, e.shown);
                end
                checks++;
                if (an === 2'b00) begin
                    errors++;
                    $display("FAIL an_both t=%0t got an=%b exp not 00", $time, an);
                end
            end
        end
    end

    task automatic step(input logic [6:0] s, input logic [1:0] a, input logic r, input logic [3:0] v);
        q.push_back('{seg: s, an: a, rdy: r, shown: v});
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic [6:0] s, input logic [1:0] a, input logic r, input logic [3:0] v);
        for (int i = 0; i < n; i++) step(s, a, r, v);
    endtask

    task automatic offer(input logic [3:0] v, input logic [3:0] prev);
        in_valid = 1'b1;
        value    = v;
        step(7'h7F, 2'b11, 1'b1, prev);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] us, ts;
        logic [1:0] ta;
        logic [3:0] prev;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        steps(10, 7'h7F, 2'b11, 1'b1, 4'd0);
        // 7: gap, units lit, gap, dark tens, gap
        offer(4'd7, 4'd0);
        step(7'h7F, 2'b11, 1'b1, 4'd7);
        steps(4, 7'h78, 2'b10, 1'b0, 4'd7);
        step(7'h7F, 2'b11, 1'b1, 4'd7);
        steps(4, 7'h7F, 2'b11, 1'b0, 4'd7);
        // 13 captured in GAP_U
        offer(4'd13, 4'd7);
        steps(4, 7'h30, 2'b10, 1'b0, 4'd13);
        step(7'h7F, 2'b11, 1'b1, 4'd13);
        steps(4, 7'h79, 2'b01, 1'b0, 4'd13);
        step(7'h7F, 2'b11, 1'b1, 4'd13);
        // 9 held through UNITS, accepted in GAP_T
        in_valid = 1'b1;
        value    = 4'd9;
        steps(4, 7'h30, 2'b10, 1'b0, 4'd13);
        step(7'h7F, 2'b11, 1'b1, 4'd13);
        in_valid = 1'b0;
        steps(4, 7'h7F, 2'b11, 1'b0, 4'd9);
        step(7'h7F, 2'b11, 1'b1, 4'd9);
        steps(4, 7'h10, 2'b10, 1'b0, 4'd9);
        // blank beats capture in GAP_T
        blank    = 1'b1;
        in_valid = 1'b1;
        value    = 4'd5;
        step(7'h7F, 2'b11, 1'b0, 4'd9);
        blank    = 1'b0;
        in_valid = 1'b0;
        steps(2, 7'h7F, 2'b11, 1'b1, 4'd9);
        // sweep all values, blanking each after one full period
        prev = 4'd9;
        for (int v = 0; v < 16; v++) begin
            us = ENC[v % 10];
            ts = (v >= 10) ? 7'h79 : 7'h7F;
            ta = (v >= 10) ? 2'b01 : 2'b11;
            offer(4'(v), prev);
            step(7'h7F, 2'b11, 1'b1, 4'(v));
            steps(4, us, 2'b10, 1'b0, 4'(v));
            step(7'h7F, 2'b11, 1'b1, 4'(v));
            steps(4, ts, ta, 1'b0, 4'(v));
            blank = 1'b1;
            step(7'h7F, 2'b11, 1'b0, 4'(v));
            blank = 1'b0;
            prev = 4'(v);
        end
        step(7'h7F, 2'b11, 1'b1, 4'd15);
        // reset mid-TENS
        offer(4'd12, 4'd15);
        step(7'h7F, 2'b11, 1'b1, 4'd12);
        steps(4, 7'h24, 2'b10, 1'b0, 4'd12);
        step(7'h7F, 2'b11, 1'b1, 4'd12);
        steps(2, 7'h79, 2'b01, 1'b0, 4'd12);
        rst = 1'b1;
        step(7'h79, 2'b01, 1'b0, 4'd12);
        rst = 1'b0;
        steps(3, 7'h7F, 2'b11, 1'b1, 4'd0);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && q.size() == 0) && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout got queue=%0d exp 0", q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
